per_rx_buffer: RTL and testbench
================================

# per_rx_buffer

Peripheral-side receiver for the 4-bit send/ack handshake driven by the CPU. Captures each word the CPU sends, acknowledges it with a four-phase handshake, and queues it in a small FIFO that local peripheral logic drains. Sits between the CPU's `cpu_send`/`cpu_dados` outputs and the peripheral's internal datapath. Applies backpressure by withholding `per_ack` while the FIFO is full.

## Interface
- `DATA_W`, 4: handshake data width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `per_clock` in 1: peripheral clock, rising edge.
- `per_reset` in 1: asynchronous, active-low reset.
- `per_send` in 1: request from CPU; level, held until `per_ack` seen.
- `in_per_dados` in DATA_W: CPU data, stable while `per_send`=1.
- `per_ack` out 1: acknowledge to CPU; registered.
- `rd_en` in 1: pop head word.
- `rd_data` out DATA_W: head word (first-word-fall-through); 0 when empty.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO holds DEPTH words.
- `count` out $clog2(DEPTH+1): words stored.

## Operation
- Handshake FSM, two states:
  - IDLE: `per_ack`=0. If `send_s`=1 and `full`=0 → write `in_per_dados` into FIFO, set `per_ack`=1, go ACK. If `send_s`=1 and `full`=1 → stay IDLE, no write (backpressure).
  - ACK: `per_ack`=1. When `send_s`=0 → clear `per_ack`, go IDLE. No write in ACK.
- Exactly one FIFO write per send pulse; `send_s` is the (optionally synchronized) `per_send`.
- FIFO: circular buffer, pointers wrap modulo DEPTH; `count` increments on write, decrements on read, unchanged on simultaneous read+write.
- Read with `empty`=1 ignored; no state change, `count` stays 0.
- Write decision uses registered `full`; a read in the same cycle as a full-blocked send does not allow that write; write occurs next cycle.
- Reset values: `per_ack`=0, `empty`=1, `full`=0, `count`=0, `rd_data`=0, FSM=IDLE, pointers=0, sync flops=0.
- Reset mid-handshake: `per_ack` drops immediately (async), FIFO contents discarded. If `per_send` is still high after reset release, the word is captured again as a new transfer.

## Timing
- E0 = first rising edge sampling `per_send`=1.
- With sync: `per_ack` and write registered at E2 (2-cycle latency); `count`/`empty` update at E2.
- Without sync: `per_ack` and write registered at E0.
- Release: `per_ack` falls 2 edges (sync) or 0 edges (no sync) after first edge sampling `per_send`=0.
- `rd_data` valid combinationally whenever `empty`=0; pop takes effect at the `rd_en` edge; next head visible after it.
- Sustained throughput: one word per 4-phase cycle; minimum 6 `per_clock` cycles per word with sync, 2 without.

## Configuration
- `PER_RX_SYNC_EN` defined: two-flop synchronizer on `per_send`; supports CPU on an unrelated clock.
- Undefined: `send_s` = `per_send` directly; only legal when CPU and peripheral share `per_clock`. Latencies per Timing.

## Structure
- Package `per_rx_pkg`: FSM state enum (IDLE, ACK), default `DATA_W`/`DEPTH` constants.
- Sub-module `per_rx_fifo`: storage, pointers, count, flags, FWFT read; top holds synchronizer and handshake FSM.

## Test plan
- Single transfer: send 4'hA → `per_ack` high at E2 (sync), `count`=1, `rd_data`=4'hA; drop send → ack low 2 edges later.
- Fill: four transfers 1,2,3,4 with no reads → `full`=1, `count`=4; fifth send (4'h5) → `per_ack` stays 0.
- Backpressure release: from full, pulse `rd_en` once → `rd_data` 1→2, then pending 4'h5 written, ack rises, reads return 2,3,4,5 in order.
- Simultaneous read+write at `count`=2 → `count` stays 2, order preserved.
- Read when empty → `empty`=1, `count`=0, `rd_data`=0, no underflow.
- Reset asserted while `per_ack`=1 and `count`=3 → `per_ack`=0, `count`=0, `empty`=1 immediately; send held high across release → one new capture.

Source files
------------

// File: rtl/per_rx_pkg.sv
// Shared types and default sizing for the peripheral-side receive buffer.
package per_rx_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/per_rx_if.sv
// Send/ack handshake plus local drain port of the receive buffer.
interface per_rx_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              per_send;
  logic [DATA_W-1:0] in_per_dados;
  logic              per_ack;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport master (
    output per_send, in_per_dados, rd_en,
    input  per_ack, rd_data, empty, full, count
  );

  modport slave (
    input  per_send, in_per_dados, rd_en,
    output per_ack, rd_data, empty, full, count
  );

endinterface

// File: rtl/per_rx_fifo.sv
// Circular FIFO with first-word-fall-through head, registered count and flags.
module per_rx_fifo
  import per_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_rd_en,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;

  logic              w_wr_fire;
  logic              w_rd_fire;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_wr_fire = i_wr_en && !r_full;
  assign w_rd_fire = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_fire, w_rd_fire})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wptr] <= i_wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_wr_fire) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_fire) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign o_rd_data = r_empty ? '0 : r_mem[r_rptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_count   = r_count;

endmodule

// File: rtl/per_rx_buffer.sv
// Peripheral receiver: four-phase send/ack capture into a small FIFO.
// Define PER_RX_SYNC_EN to add a two-flop synchronizer on per_send.
module per_rx_buffer
  import per_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic    per_clock,
  input  logic    per_reset,
  per_rx_if.slave bus
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_ack;
  logic   w_ack_nxt;
  logic   w_wr_en;
  logic   w_send_s;
  logic   w_full;

`ifdef PER_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) r_sync <= 2'b00;
    else            r_sync <= {r_sync[0], bus.per_send};
  end

  assign w_send_s = r_sync[1];
`else
  assign w_send_s = bus.per_send;
`endif

  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Registered full gates the write, so a same-cycle pop cannot admit it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_send_s && !w_full) w_state_nxt = ST_ACK;
      ST_ACK:  if (!w_send_s)           w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_ack_nxt = (w_state_nxt == ST_ACK);
    if (r_state == ST_IDLE && w_send_s && !w_full) w_wr_en = 1'b1;
  end

  per_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (per_clock),
    .rst_n     (per_reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (bus.in_per_dados),
    .i_rd_en   (bus.rd_en),
    .o_rd_data (bus.rd_data),
    .o_empty   (bus.empty),
    .o_full    (w_full),
    .o_count   (bus.count)
  );

  assign bus.full    = w_full;
  assign bus.per_ack = r_ack;

endmodule

// File: tb/tb_per_rx_buffer.sv
// Directed self-checking bench for per_rx_buffer (either synchronizer build).
module tb_per_rx_buffer;

`ifdef PER_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  per_rx_if #(.DATA_W(4), .DEPTH(4)) bus ();

  per_rx_buffer #(.DATA_W(4), .DEPTH(4)) dut (
    .per_clock (clk),
    .per_reset (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    bus.per_send     = 1'b1;
    bus.in_per_dados = d;
    tick(1 + LAT);
    check("send_ack_rise", 32'(bus.per_ack), 32'd1);
    bus.per_send = 1'b0;
    tick(1 + LAT);
    check("send_ack_fall", 32'(bus.per_ack), 32'd0);
  endtask

  task automatic pop(input logic [3:0] exp_head);
    check("pop_head", 32'(bus.rd_data), 32'(exp_head));
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    clk              = 1'b0;
    rst_n            = 1'b0;
    checks           = 0;
    errors           = 0;
    bus.per_send     = 1'b0;
    bus.in_per_dados = 4'h0;
    bus.rd_en        = 1'b0;
    tick(2);

    check("rst_ack",   32'(bus.per_ack), 32'd0);
    check("rst_empty", 32'(bus.empty),   32'd1);
    check("rst_full",  32'(bus.full),    32'd0);
    check("rst_count", 32'(bus.count),   32'd0);
    check("rst_data",  32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single transfer
    bus.per_send     = 1'b1;
    bus.in_per_dados = 4'hA;
    tick(1 + LAT);
    check("single_ack",   32'(bus.per_ack), 32'd1);
    check("single_count", 32'(bus.count),   32'd1);
    check("single_data",  32'(bus.rd_data), 32'hA);
    check("single_empty", 32'(bus.empty),   32'd0);
    bus.per_send = 1'b0;
    tick(1 + LAT);
    check("single_release", 32'(bus.per_ack), 32'd0);
    check("single_no_dup",  32'(bus.count),   32'd1);
    pop(4'hA);
    check("single_drained", 32'(bus.empty), 32'd1);

    // Fill to full
    for (int i = 1; i <= 4; i++) send(4'(i));
    check("fill_full",  32'(bus.full),    32'd1);
    check("fill_count", 32'(bus.count),   32'd4);
    check("fill_head",  32'(bus.rd_data), 32'h1);

    // Fifth send is held off
    bus.per_send     = 1'b1;
    bus.in_per_dados = 4'h5;
    tick(3 + LAT);
    check("bp_ack_low", 32'(bus.per_ack), 32'd0);
    check("bp_count",   32'(bus.count),   32'd4);

    // One pop frees a slot; the pending word lands the following cycle
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("bp_head_next", 32'(bus.rd_data), 32'h2);
    check("bp_count_dec", 32'(bus.count),   32'd3);
    check("bp_no_same",   32'(bus.per_ack), 32'd0);
    tick(1);
    check("bp_ack_rise",  32'(bus.per_ack), 32'd1);
    check("bp_count_inc", 32'(bus.count),   32'd4);
    check("bp_full",      32'(bus.full),    32'd1);
    bus.per_send = 1'b0;
    tick(1 + LAT);
    check("bp_release", 32'(bus.per_ack), 32'd0);
    for (int i = 2; i <= 5; i++) pop(4'(i));
    check("bp_empty", 32'(bus.empty), 32'd1);

    // Read while empty
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("uf_empty", 32'(bus.empty),   32'd1);
    check("uf_count", 32'(bus.count),   32'd0);
    check("uf_data",  32'(bus.rd_data), 32'd0);

    // Simultaneous read and write at count 2
    send(4'h7);
    send(4'h8);
    check("rw_pre_count", 32'(bus.count), 32'd2);
    bus.per_send     = 1'b1;
    bus.in_per_dados = 4'h9;
    tick(LAT);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("rw_ack",   32'(bus.per_ack), 32'd1);
    check("rw_count", 32'(bus.count),   32'd2);
    check("rw_head",  32'(bus.rd_data), 32'h8);
    bus.per_send = 1'b0;
    tick(1 + LAT);
    pop(4'h8);
    pop(4'h9);
    check("rw_empty", 32'(bus.empty), 32'd1);

    // Reset in the middle of a handshake
    send(4'h1);
    send(4'h2);
    bus.per_send     = 1'b1;
    bus.in_per_dados = 4'h3;
    tick(1 + LAT);
    check("mr_ack",   32'(bus.per_ack), 32'd1);
    check("mr_count", 32'(bus.count),   32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_rst_ack",   32'(bus.per_ack), 32'd0);
    check("mr_rst_count", 32'(bus.count),   32'd0);
    check("mr_rst_empty", 32'(bus.empty),   32'd1);
    #1;
    rst_n = 1'b1;
    tick(1 + LAT);
    check("mr_recap_ack",   32'(bus.per_ack), 32'd1);
    check("mr_recap_count", 32'(bus.count),   32'd1);
    check("mr_recap_data",  32'(bus.rd_data), 32'h3);
    bus.per_send = 1'b0;
    tick(1 + LAT);
    check("mr_release", 32'(bus.per_ack), 32'd0);
    check("mr_single",  32'(bus.count),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
